ibex_clock_gate: RTL and testbench

- Glitch-free integrated clock-gating cell: forwards clock clk_int to clk_o only in cycles where the functional or test enable is active.
- Used by the latch-based register file in two roles:
  - a global write gate, enabled by the write enable;
  - one per-word gate per register, enabled by the one-hot write address.
- Behavioural, technology-independent implementation; synthesis flows may swap in a library ICG with identical port semantics.

---
 rtl/ibex_clock_gate.sv | 45 ++++
 tb/tb_ibex_clock_gate.sv | 95 +++++++++
 2 files changed

// File: rtl/ibex_clock_gate.sv
// ibex_clock_gate: glitch-free clock gate passing clk_int to clk_o only in enabled cycles
// Ports:
//   clk_int   - clock to be gated
//   rst_ni    - async active-low reset of the stored enable (loads RESET_EN)
//   en_i      - functional enable, sampled while clk_int is low
//   test_en_i - scan/test enable, forces the clock through
//   clk_o     - gated clock
//   en_q_o    - stored enable, for status/debug
// GATE_STYLE: 0 = latch transparent while clk_int low, 1 = flop on falling clk_int.
module ibex_clock_gate #(
    parameter int GATE_STYLE = 0,
    parameter bit RESET_EN   = 1'b0
) (
    input  logic clk_int,
    input  logic rst_ni,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o,
    output logic en_q_o
);
    logic en_eff;
    logic en_q;
    assign en_eff = en_i | test_en_i;
    generate
        if (GATE_STYLE == 0) begin : g_latch
            always_latch begin
                if (!rst_ni) en_q = RESET_EN;
                else if (!clk_int) en_q = en_eff;
            end
        end else begin : g_flop
            always_ff @(negedge clk_int or negedge rst_ni) begin
                if (!rst_ni) en_q <= RESET_EN;
                else en_q <= en_eff;
            end
        end
    endgenerate
    // en_q is frozen for the whole high phase, so the AND can only pass full pulses.
    assign clk_o  = clk_int & en_q;
    assign en_q_o = en_q;
`ifndef SYNTHESIS
    always @(posedge clk_o) assert (clk_int) else $error("clk_o high while clk_int low");
    // clk_o can only rise off a clk_int edge if the stored enable changed mid-high-phase.
    always @(posedge en_q) assert (!clk_int) else $error("clk_o rose without a clk_int rising edge");
`endif
endmodule

// File: tb/tb_ibex_clock_gate.sv
// tb_ibex_clock_gate: randomized self-checking bench for ibex_clock_gate
module tb_ibex_clock_gate;
    logic clk_int = 1'b0;
    logic rst_ni = 1'b0;
    logic en_i = 1'b0;
    logic test_en_i = 1'b0;
    logic clk_o;
    logic en_q_o;
    int n_checks = 0;
    int n_fail = 0;

    ibex_clock_gate #(.GATE_STYLE(0), .RESET_EN(1'b0)) u_dut (
        .clk_int(clk_int),
        .rst_ni(rst_ni),
        .en_i(en_i),
        .test_en_i(test_en_i),
        .clk_o(clk_o),
        .en_q_o(en_q_o)
    );

    always #5 clk_int = ~clk_int;

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
        end
    endtask

    // One clk_int period: enables (e,t) in the low phase, a (ge,gt) excursion in the
    // high phase that is restored before it ends, optional async reset late in the
    // high phase, optional reset release at the start of the low phase.
    task automatic run_cycle(input logic e, input logic t, input logic ge, input logic gt,
                             input logic arst, input logic rel);
        logic pass;
        @(negedge clk_int);
        #1;
        if (rel) rst_ni = 1'b1;
        en_i = e;
        test_en_i = t;
        #1;
        check("low_clk", clk_o, 1'b0);
        check("low_q", en_q_o, rst_ni ? (e | t) : 1'b0);
        @(posedge clk_int);
        pass = rst_ni && (e | t);
        #1;
        check("rise_clk", clk_o, pass);
        check("rise_q", en_q_o, pass);
        en_i = ge;
        test_en_i = gt;
        #1;
        check("glitch_clk", clk_o, pass);
        check("glitch_q", en_q_o, pass);
        en_i = e;
        test_en_i = t;
        #1;
        if (arst) begin
            rst_ni = 1'b0;
            pass = 1'b0;
        end
        #1;
        check("late_clk", clk_o, pass);
        check("late_q", en_q_o, pass);
    endtask

    initial begin
        en_i = 1'b1;
        #1;
        check("rst_q", en_q_o, 1'b0);
        check("rst_clk", clk_o, 1'b0);
        repeat (3) run_cycle(1, 0, 1, 0, 0, 0);
        run_cycle(1, 0, 1, 0, 0, 1);
        repeat (3) run_cycle(0, 0, 0, 0, 0, 0);
        run_cycle(1, 0, 1, 0, 0, 0);
        run_cycle(0, 0, 0, 0, 0, 0);
        run_cycle(0, 0, 1, 0, 0, 0);
        run_cycle(0, 0, 0, 0, 0, 0);
        run_cycle(1, 0, 0, 0, 0, 0);
        run_cycle(0, 0, 0, 0, 0, 0);
        repeat (10) run_cycle(0, 1, 0, 0, 0, 0);
        run_cycle(0, 0, 0, 0, 0, 0);
        run_cycle(0, 0, 0, 0, 0, 0);
        run_cycle(1, 0, 1, 0, 1, 0);
        run_cycle(1, 0, 1, 0, 0, 0);
        run_cycle(1, 0, 1, 0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 19) == 0), !rst_ni && 1'($urandom_range(0, 1)));
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
